mem_access_unit: RTL and testbench

// Load/store sequencer driving the register-file write port (MemInstruction/MemData/SelZ).

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared codes and state encodings for the load/store sequencer
package mem_access_unit_pkg;

    // Operation codes presented by the decoder on op_kind
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_MOVI  = 2'b11
    } op_kind_e;

    // Register-file bus codes driven on MemInstruction
    typedef enum logic [1:0] {
        MI_NOP   = 2'b00,
        MI_READ  = 2'b01,
        MI_WRITE = 2'b10,
        MI_WRGP  = 2'b11
    } mem_instr_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LD_WAIT = 2'b01,
        S_ST_WAIT = 2'b10,
        S_WRBACK  = 2'b11
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait-cycle counter that flags the last allowed wait cycle
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous reset, active-low
//   clear   in   restart the count (operation accepted)
//   enable  in   one more wait cycle without a memory acknowledge
//   expired out  current wait cycle is the TIMEOUT-th one without an acknowledge
module mem_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] SAT  = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // The count reaches TIMEOUT at the end of this cycle if no acknowledge arrives,
    // so the sequencer aborts on this edge rather than waiting one more cycle.
    assign expired = (count >= LAST);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer driving data memory and the register-file write port
//
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   op_valid/op_ready               decoder handshake, one operation at a time
//   op_kind/op_addr/op_data/op_dst  operation code, address, store data or immediate, destination
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  data-memory req/ack transaction
//   MemInstruction/MemData/SelZ     register-file bus code, write-back data and index
//   err_timeout                     sticky abort flag, cleared when the next op is accepted
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_kind,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_data,
    input  logic [2:0]        op_dst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        MemInstruction,
    output logic [31:0]       MemData,
    output logic [2:0]        SelZ,
    output logic              err_timeout
);

    import mem_access_unit_pkg::*;

    state_e            state, state_nxt;
    logic              op_ready_nxt;
    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [31:0]       mem_wdata_nxt;
    logic [1:0]        mi_nxt;
    logic [31:0]       mem_data_nxt;
    logic [2:0]        selz_nxt;
    logic              err_nxt;
    logic [2:0]        dst_q, dst_nxt;

    logic accept;
    logic waiting;
    logic expired;

    assign accept  = op_valid && op_ready;
    assign waiting = (state == S_LD_WAIT) || (state == S_ST_WAIT);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (waiting && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_nxt     = state;
        op_ready_nxt  = op_ready;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mi_nxt        = MemInstruction;
        mem_data_nxt  = MemData;
        selz_nxt      = SelZ;
        err_nxt       = err_timeout;
        dst_nxt       = dst_q;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    // Any accepted op, NOP included, clears the sticky abort flag.
                    err_nxt = 1'b0;
                    case (op_kind)
                        OP_LOAD: begin
                            state_nxt    = S_LD_WAIT;
                            op_ready_nxt = 1'b0;
                            mem_req_nxt  = 1'b1;
                            mem_we_nxt   = 1'b0;
                            mem_addr_nxt = op_addr;
                            mi_nxt       = MI_READ;
                            dst_nxt      = op_dst;
                        end
                        OP_STORE: begin
                            state_nxt     = S_ST_WAIT;
                            op_ready_nxt  = 1'b0;
                            mem_req_nxt   = 1'b1;
                            mem_we_nxt    = 1'b1;
                            mem_addr_nxt  = op_addr;
                            mem_wdata_nxt = op_data;
                            mi_nxt        = MI_WRITE;
                        end
                        OP_MOVI: begin
                            state_nxt    = S_WRBACK;
                            op_ready_nxt = 1'b0;
                            mem_data_nxt = op_data;
                            selz_nxt     = op_dst;
                            mi_nxt       = MI_WRGP;
                        end
                        default: ;
                    endcase
                end
            end
            S_LD_WAIT: begin
                // Acknowledge has priority over an expiring timer.
                if (mem_ack) begin
                    state_nxt    = S_WRBACK;
                    mem_req_nxt  = 1'b0;
                    mem_data_nxt = mem_rdata;
                    selz_nxt     = dst_q;
                    mi_nxt       = MI_WRGP;
                end else if (expired) begin
                    state_nxt    = S_IDLE;
                    op_ready_nxt = 1'b1;
                    mem_req_nxt  = 1'b0;
                    mi_nxt       = MI_NOP;
                    err_nxt      = 1'b1;
                end
            end
            S_ST_WAIT: begin
                if (mem_ack || expired) begin
                    state_nxt    = S_IDLE;
                    op_ready_nxt = 1'b1;
                    mem_req_nxt  = 1'b0;
                    mem_we_nxt   = 1'b0;
                    mi_nxt       = MI_NOP;
                    err_nxt      = !mem_ack;
                end
            end
            S_WRBACK: begin
                state_nxt    = S_IDLE;
                op_ready_nxt = 1'b1;
                mi_nxt       = MI_NOP;
            end
            default: begin
                state_nxt    = S_IDLE;
                op_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            op_ready       <= 1'b1;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            MemInstruction <= MI_NOP;
            MemData        <= '0;
            SelZ           <= '0;
            err_timeout    <= 1'b0;
            dst_q          <= '0;
        end else begin
            state          <= state_nxt;
            op_ready       <= op_ready_nxt;
            mem_req        <= mem_req_nxt;
            mem_we         <= mem_we_nxt;
            mem_addr       <= mem_addr_nxt;
            mem_wdata      <= mem_wdata_nxt;
            MemInstruction <= mi_nxt;
            MemData        <= mem_data_nxt;
            SelZ           <= selz_nxt;
            err_timeout    <= err_nxt;
            dst_q          <= dst_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TO    = 8;
    localparam int LIMIT = TO + 6;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [31:0] data;
        logic [2:0]  dst;
        int          ack_at;
        logic [31:0] rdata;
        int          e_req;
        int          e_wb;
        int          e_wbcyc;
        logic [31:0] e_data;
        logic [2:0]  e_sel;
        int          e_ready;
        logic        e_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_kind;
    logic [15:0] op_addr;
    logic [31:0] op_data;
    logic [2:0]  op_dst;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  MemInstruction;
    logic [31:0] MemData;
    logic [2:0]  SelZ;
    logic        err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(
        .ADDR_W  (16),
        .TIMEOUT (TO),
        .TO_W    (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_kind        (op_kind),
        .op_addr        (op_addr),
        .op_data        (op_data),
        .op_dst         (op_dst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .MemInstruction (MemInstruction),
        .MemData        (MemData),
        .SelZ           (SelZ),
        .err_timeout    (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] kind, input logic [15:0] addr, input logic [31:0] data,
                                input logic [2:0] dst, input int ack_at, input logic [31:0] rdata,
                                input int e_req, input int e_wb, input int e_wbcyc, input logic [31:0] e_data,
                                input logic [2:0] e_sel, input int e_ready, input logic e_err);
        vec_t v;
        v.kind = kind; v.addr = addr; v.data = data; v.dst = dst; v.ack_at = ack_at; v.rdata = rdata;
        v.e_req = e_req; v.e_wb = e_wb; v.e_wbcyc = e_wbcyc; v.e_data = e_data; v.e_sel = e_sel;
        v.e_ready = e_ready; v.e_err = e_err;
        return v;
    endfunction

    // Expected outcome of one operation, in cycles counted from the accept edge.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.e_req = 0; r.e_wb = 0; r.e_wbcyc = 0; r.e_data = '0; r.e_sel = '0; r.e_ready = 1; r.e_err = 1'b0;
        if (v.kind == 2'b11) begin
            r.e_wb = 1; r.e_wbcyc = 1; r.e_data = v.data; r.e_sel = v.dst; r.e_ready = 2;
        end else if (v.kind != 2'b00) begin
            if (v.ack_at <= TO) begin
                r.e_req = v.ack_at;
                if (v.kind == 2'b01) begin
                    r.e_wb = 1; r.e_wbcyc = v.ack_at + 1; r.e_data = v.rdata; r.e_sel = v.dst;
                    r.e_ready = v.ack_at + 2;
                end else begin
                    r.e_ready = v.ack_at + 1;
                end
            end else begin
                r.e_req = TO; r.e_ready = TO + 1; r.e_err = 1'b1;
            end
        end
        return r;
    endfunction

    // Called at a falling edge with the unit idle; returns at the falling edge where op_ready is back.
    task automatic run_op(input vec_t v, input string tag);
        int          req_n = 0;
        int          wb_n  = 0;
        int          wb_c  = 0;
        int          rdy_c = 0;
        int          bad   = 0;
        logic [31:0] wd    = '0;
        logic [2:0]  ws    = '0;
        logic        er    = 1'b0;
        op_valid = 1'b1; op_kind = v.kind; op_addr = v.addr; op_data = v.data; op_dst = v.dst;
        check(tag, "ready_before", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= LIMIT && rdy_c == 0; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
            op_kind  = 2'($urandom);
            op_addr  = 16'($urandom);
            op_data  = $urandom;
            mem_ack  = 1'b0;
            if (mem_req) begin
                req_n++;
                if (MemInstruction != ((v.kind == 2'b01) ? 2'b01 : 2'b10)) bad++;
                if (mem_we != (v.kind == 2'b10)) bad++;
                if (mem_addr != v.addr) bad++;
                if (v.kind == 2'b10 && mem_wdata != v.data) bad++;
                if (op_ready) bad++;
            end
            if (MemInstruction == 2'b11) begin
                wb_n++; wb_c = c; wd = MemData; ws = SelZ;
            end
            if (op_ready) begin
                rdy_c = c; er = err_timeout;
            end else begin
                if (err_timeout) bad++;
                if (c == v.ack_at) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end else begin
                    mem_rdata = $urandom;
                end
            end
        end
        mem_ack = 1'b0;
        check(tag, "req_cycles", req_n, v.e_req);
        check(tag, "wb_count", wb_n, v.e_wb);
        if (v.e_wb != 0) begin
            check(tag, "wb_cycle", wb_c, v.e_wbcyc);
            check(tag, "MemData", wd, v.e_data);
            check(tag, "SelZ", {29'd0, ws}, {29'd0, v.e_sel});
        end
        check(tag, "ready_cycle", rdy_c, v.e_ready);
        check(tag, "err_timeout", {31'd0, er}, {31'd0, v.e_err});
        check(tag, "wait_phase_errors", bad, 0);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        rst = 1'b0; op_valid = 1'b0; op_kind = 2'b00; op_addr = '0; op_data = '0; op_dst = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", "op_ready", {31'd0, op_ready}, 32'd1);
        check("reset", "mem_req", {31'd0, mem_req}, 32'd0);
        check("reset", "mem_we", {31'd0, mem_we}, 32'd0);
        check("reset", "mem_addr", {16'd0, mem_addr}, 32'd0);
        check("reset", "mem_wdata", mem_wdata, 32'd0);
        check("reset", "MemInstruction", {30'd0, MemInstruction}, 32'd0);
        check("reset", "MemData", MemData, 32'd0);
        check("reset", "SelZ", {29'd0, SelZ}, 32'd0);
        check("reset", "err_timeout", {31'd0, err_timeout}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed table: kind addr data dst ack_at rdata | req wb wbcyc data sel ready err
        tbl[0] = mk(2'b11, 16'h0000, 32'hDEADBEEF, 3'd5, 1,   32'h0,        0, 1, 1, 32'hDEADBEEF, 3'd5, 2, 1'b0);
        tbl[1] = mk(2'b01, 16'h0040, 32'h0,        3'd3, 5,   32'h12345678, 5, 1, 6, 32'h12345678, 3'd3, 7, 1'b0);
        tbl[2] = mk(2'b10, 16'h0010, 32'hA5A5A5A5, 3'd0, 2,   32'h0,        2, 0, 0, 32'h0,        3'd0, 3, 1'b0);
        tbl[3] = mk(2'b01, 16'h0044, 32'h0,        3'd2, 200, 32'h0,        8, 0, 0, 32'h0,        3'd0, 9, 1'b1);
        tbl[4] = mk(2'b00, 16'h0000, 32'h0,        3'd0, 1,   32'h0,        0, 0, 0, 32'h0,        3'd0, 1, 1'b0);
        tbl[5] = mk(2'b01, 16'h1234, 32'h0,        3'd0, 8,   32'hCAFEF00D, 8, 1, 9, 32'hCAFEF00D, 3'd0, 10, 1'b0);
        tbl[6] = mk(2'b10, 16'hFFFF, 32'h0F0F0F0F, 3'd1, 9,   32'h0,        8, 0, 0, 32'h0,        3'd0, 9, 1'b1);
        tbl[7] = mk(2'b11, 16'h0000, 32'h00000000, 3'd0, 1,   32'h0,        0, 1, 1, 32'h0,        3'd0, 2, 1'b0);
        tbl[8] = mk(2'b01, 16'h8000, 32'h0,        3'd7, 1,   32'hFFFFFFFF, 1, 1, 2, 32'hFFFFFFFF, 3'd7, 3, 1'b0);
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rv.kind   = 2'($urandom_range(0, 3));
            rv.addr   = 16'($urandom);
            rv.data   = $urandom;
            rv.dst    = 3'($urandom_range(0, 7));
            rv.ack_at = $urandom_range(1, TO + 2);
            rv.rdata  = $urandom;
            run_op(model(rv), $sformatf("rnd%0d", i));
        end

        // Back-to-back STOREs with op_valid held high
        begin
            int   acc   = 0;
            int   rises = 0;
            int   ovl   = 0;
            int   run   = 0;
            int   drain = 0;
            logic prev  = 1'b0;
            op_valid = 1'b1; op_kind = 2'b10; op_addr = 16'h0200; op_data = 32'h13579BDF; op_dst = 3'd0;
            for (int s = 1; s <= 12; s++) begin
                mem_ack = 1'b0;
                if (op_ready && mem_req) ovl++;
                if (op_ready && op_valid) acc++;
                if (mem_req && !prev) rises++;
                prev = mem_req;
                run  = mem_req ? run + 1 : 0;
                if (run == 2) mem_ack = 1'b1;
                if (s == 12) op_valid = 1'b0;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            while (!op_ready && drain < 20) begin
                if (mem_req && !prev) rises++;
                prev = mem_req;
                drain++;
                @(negedge clk);
            end
            check("b2b", "accepts", acc, 4);
            check("b2b", "req_starts", rises, acc);
            check("b2b", "req_ready_overlap", ovl, 0);
            check("b2b", "ready_after_drain", {31'd0, op_ready}, 32'd1);
        end

        // Reset in the middle of LD_WAIT with an acknowledge arriving during reset
        run_op(mk(2'b11, 16'h0, 32'h11111111, 3'd6, 1, 32'h0, 0, 1, 1, 32'h11111111, 3'd6, 2, 1'b0), "pre_rst");
        begin
            int wb_seen = 0;
            int not_rdy = 0;
            op_valid = 1'b1; op_kind = 2'b01; op_addr = 16'h0123; op_dst = 3'd6;
            @(posedge clk);
            @(negedge clk);
            op_valid = 1'b0;
            check("rst_mid", "req_before_reset", {31'd0, mem_req}, 32'd1);
            @(negedge clk);
            rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
            @(negedge clk);
            mem_ack = 1'b0;
            check("rst_mid", "mem_req", {31'd0, mem_req}, 32'd0);
            check("rst_mid", "MemInstruction", {30'd0, MemInstruction}, 32'd0);
            check("rst_mid", "op_ready", {31'd0, op_ready}, 32'd1);
            check("rst_mid", "MemData", MemData, 32'd0);
            check("rst_mid", "SelZ", {29'd0, SelZ}, 32'd0);
            @(negedge clk);
            rst = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (MemInstruction == 2'b11) wb_seen++;
                if (!op_ready) not_rdy++;
            end
            check("rst_mid", "wb_after_reset", wb_seen, 0);
            check("rst_mid", "not_ready_after_reset", not_rdy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
